// File: rtl/dma_rd_sched.sv
// dma_rd_sched: round-robin scheduler that hands read jobs from two requesters
// to a single DMA read engine, routes the returned beats back to the owner,
// enforces an idle gap between jobs and flags beat-count mismatches.
module dma_rd_sched #(
    parameter int BITS_TRANS   = 18,
    parameter int AXI_WIDTH_AD = 32,
    parameter int AXI_WIDTH_DA = 32,
    parameter int GAP_CYCLES   = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [AXI_WIDTH_AD-1:0] req0_addr,
    input  logic [BITS_TRANS-1:0]   req0_len,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [AXI_WIDTH_AD-1:0] req1_addr,
    input  logic [BITS_TRANS-1:0]   req1_len,
    output logic                    dma_start,
    output logic [BITS_TRANS-1:0]   dma_num_trans,
    output logic [AXI_WIDTH_AD-1:0] dma_start_addr,
    input  logic [AXI_WIDTH_DA-1:0] dma_data,
    input  logic                    dma_data_vld,
    input  logic                    dma_done,
    output logic [AXI_WIDTH_DA-1:0] rd0_data,
    output logic                    rd0_vld,
    output logic                    rd0_done,
    output logic [AXI_WIDTH_DA-1:0] rd1_data,
    output logic                    rd1_vld,
    output logic                    rd1_done,
    output logic                    busy,
    output logic                    cnt_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_BUSY  = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_ZERO  = 3'd4;

    // A GAP_CYCLES of 0 still spends one cycle in GAP; the counter needs at least one bit.
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    logic [2:0]              r_state;
    logic                    r_last_grant;
    logic                    r_owner;
    logic [BITS_TRANS-1:0]   r_len;
    logic [AXI_WIDTH_AD-1:0] r_addr;
    logic [BITS_TRANS-1:0]   r_beat_cnt;
    logic [GAP_W-1:0]        r_gap_cnt;
    logic                    r_cnt_err;
    logic [AXI_WIDTH_DA-1:0] r_rd0_data;
    logic [AXI_WIDTH_DA-1:0] r_rd1_data;
    logic                    r_rd0_vld;
    logic                    r_rd1_vld;
    logic                    r_rd0_done;
    logic                    r_rd1_done;

    logic                    w_accept;
    logic                    w_grant1;
    logic [AXI_WIDTH_AD-1:0] w_sel_addr;
    logic [BITS_TRANS-1:0]   w_sel_len;
    logic                    w_zero_accept;
    logic                    w_fwd;
    logic                    w_busy_done;
    logic [BITS_TRANS-1:0]   w_beat_total;

    // Round-robin grant: on contention the requester not served last wins.
    assign w_grant1      = req1_valid & (~req0_valid | ~r_last_grant);
    assign w_accept      = (r_state == S_IDLE) & (req0_valid | req1_valid);
    assign w_sel_addr    = w_grant1 ? req1_addr : req0_addr;
    assign w_sel_len     = w_grant1 ? req1_len : req0_len;
    assign w_zero_accept = w_accept & (w_sel_len == '0);
    assign w_fwd         = (r_state == S_BUSY) & dma_data_vld;
    assign w_busy_done   = (r_state == S_BUSY) & dma_done;
    assign w_beat_total  = r_beat_cnt + {{(BITS_TRANS-1){1'b0}}, dma_data_vld};

    // Ready is a same-cycle handshake; it is masked by rstn so it reads 0 while held in reset.
    assign req0_ready     = rstn & w_accept & ~w_grant1;
    assign req1_ready     = rstn & w_accept & w_grant1;
    assign dma_start      = (r_state == S_ISSUE);
    assign dma_num_trans  = r_len;
    assign dma_start_addr = r_addr;
    assign busy           = (r_state != S_IDLE);
    assign cnt_err        = r_cnt_err;
    assign rd0_data       = r_rd0_data;
    assign rd1_data       = r_rd1_data;
    assign rd0_vld        = r_rd0_vld;
    assign rd1_vld        = r_rd1_vld;
    assign rd0_done       = r_rd0_done;
    assign rd1_done       = r_rd1_done;

    // Job sequencing: accept, issue to engine, count beats, then hold off for the gap.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_len        <= '0;
            r_addr       <= '0;
            r_beat_cnt   <= '0;
            r_gap_cnt    <= '0;
            r_cnt_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_owner      <= w_grant1;
                        r_last_grant <= w_grant1;
                        r_addr       <= w_sel_addr;
                        r_len        <= w_sel_len;
                        r_state      <= (w_sel_len == '0) ? S_ZERO : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_beat_cnt <= '0;
                    r_state    <= S_BUSY;
                end
                S_BUSY: begin
                    if (dma_data_vld) begin
                        r_beat_cnt <= w_beat_total;
                    end
                    if (dma_done) begin
                        if (w_beat_total != r_len) begin
                            r_cnt_err <= 1'b1;
                        end
                        r_gap_cnt <= GAP_LOAD;
                        r_state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                S_ZERO: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Registered routing of engine beats and done pulses to the owning requester.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd0_data <= '0;
            r_rd1_data <= '0;
            r_rd0_vld  <= 1'b0;
            r_rd1_vld  <= 1'b0;
            r_rd0_done <= 1'b0;
            r_rd1_done <= 1'b0;
        end else begin
            r_rd0_vld  <= w_fwd & ~r_owner;
            r_rd1_vld  <= w_fwd & r_owner;
            if (w_fwd & ~r_owner) begin
                r_rd0_data <= dma_data;
            end
            if (w_fwd & r_owner) begin
                r_rd1_data <= dma_data;
            end
            r_rd0_done <= (w_busy_done & ~r_owner) | (w_zero_accept & ~w_grant1);
            r_rd1_done <= (w_busy_done & r_owner) | (w_zero_accept & w_grant1);
        end
    end

endmodule

// File: tb/tb_dma_rd_sched.sv
// tb_dma_rd_sched: directed scenarios against dma_rd_sched with a queue-based
// scoreboard; the bench plays both requesters and the DMA read engine.
module tb_dma_rd_sched;

    localparam int BT  = 18;
    localparam int AD  = 32;
    localparam int DA  = 32;
    localparam int GAP = 4;

    logic          clk;
    logic          rstn;
    logic          req0_valid;
    logic          req0_ready;
    logic [AD-1:0] req0_addr;
    logic [BT-1:0] req0_len;
    logic          req1_valid;
    logic          req1_ready;
    logic [AD-1:0] req1_addr;
    logic [BT-1:0] req1_len;
    logic          dma_start;
    logic [BT-1:0] dma_num_trans;
    logic [AD-1:0] dma_start_addr;
    logic [DA-1:0] dma_data;
    logic          dma_data_vld;
    logic          dma_done;
    logic [DA-1:0] rd0_data;
    logic          rd0_vld;
    logic          rd0_done;
    logic [DA-1:0] rd1_data;
    logic          rd1_vld;
    logic          rd1_done;
    logic          busy;
    logic          cnt_err;

    int checks = 0;
    int errors = 0;

    logic [AD-1:0] expStartAddrQ[$];
    int            expStartLenQ[$];
    logic [DA-1:0] expRd0Q[$];
    logic [DA-1:0] expRd1Q[$];
    bit            expDone0Q[$];
    bit            expDone1Q[$];

    dma_rd_sched #(
        .BITS_TRANS(BT),
        .AXI_WIDTH_AD(AD),
        .AXI_WIDTH_DA(DA),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_addr(req0_addr),
        .req0_len(req0_len),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_addr(req1_addr),
        .req1_len(req1_len),
        .dma_start(dma_start),
        .dma_num_trans(dma_num_trans),
        .dma_start_addr(dma_start_addr),
        .dma_data(dma_data),
        .dma_data_vld(dma_data_vld),
        .dma_done(dma_done),
        .rd0_data(rd0_data),
        .rd0_vld(rd0_vld),
        .rd0_done(rd0_done),
        .rd1_data(rd1_data),
        .rd1_vld(rd1_vld),
        .rd1_done(rd1_done),
        .busy(busy),
        .cnt_err(cnt_err)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Word data the engine model returns: the byte address of each word.
    function automatic logic [DA-1:0] dataPat(input logic [AD-1:0] a, input int i);
        return a + (32'(i) * 32'd4);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: event seen/missing with no matching expectation", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise the valids, check the grant, load the scoreboard, then drop the granted valid.
    task automatic applyStimulus(input bit v0, input bit v1, input int expGrant,
                                 input int nBeats, input bit doneWithLast, input bit expectDone);
        logic [AD-1:0] a;
        logic [BT-1:0] l;
        req0_valid = v0;
        req1_valid = v1;
        #1;
        checkOutput("req0_ready_grant", 64'(req0_ready), 64'(expGrant == 0));
        checkOutput("req1_ready_grant", 64'(req1_ready), 64'(expGrant == 1));
        a = (expGrant == 0) ? req0_addr : req1_addr;
        l = (expGrant == 0) ? req0_len : req1_len;
        if (l != '0) begin
            expStartAddrQ.push_back(a);
            expStartLenQ.push_back(int'(l));
        end
        for (int i = 0; i < nBeats; i++) begin
            if (expGrant == 0) expRd0Q.push_back(dataPat(a, i));
            else               expRd1Q.push_back(dataPat(a, i));
        end
        if (expectDone) begin
            if (expGrant == 0) expDone0Q.push_back(doneWithLast);
            else               expDone1Q.push_back(doneWithLast);
        end
        tick();
        if (expGrant == 0) req0_valid = 1'b0;
        else               req1_valid = 1'b0;
        checkOutput("ready_single_cycle", 64'({req0_ready, req1_ready}), 64'(0));
        checkOutput("accept_to_start_latency", 64'(dma_start), 64'(l != '0));
    endtask

    task automatic waitStart(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (dma_start) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) reportFail("dma_start_timeout");
    endtask

    // Engine model: after dma_start, return nBeats words and signal done.
    task automatic engineRun(input logic [AD-1:0] a, input int nBeats, input bit doneWithLast);
        bit seen;
        waitStart(seen);
        if (!seen) return;
        tick();
        for (int i = 0; i < nBeats; i++) begin
            dma_data_vld = 1'b1;
            dma_data     = dataPat(a, i);
            dma_done     = doneWithLast && (i == nBeats - 1);
            tick();
        end
        dma_data_vld = 1'b0;
        dma_done     = 1'b0;
        if (!doneWithLast) begin
            dma_done = 1'b1;
            tick();
            dma_done = 1'b0;
        end
    endtask

    task automatic waitIdle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!busy) begin
                idle = 1'b1;
                break;
            end
            tick();
        end
        if (!idle) reportFail("wait_idle_timeout");
    endtask

    task automatic strayPulses(input int n);
        for (int i = 0; i < n; i++) begin
            dma_data_vld = 1'b1;
            dma_data     = 32'hDEAD_0000 + 32'(i);
            dma_done     = 1'b1;
            tick();
        end
        dma_data_vld = 1'b0;
        dma_done     = 1'b0;
    endtask

    // Monitor: every output event pops its expectation from the scoreboard.
    initial begin
        logic [AD-1:0] ea;
        int            el;
        bit            ed;
        forever begin
            @(negedge clk);
            if (dma_start) begin
                if (expStartLenQ.size() == 0) reportFail("unexpected_dma_start");
                else begin
                    ea = expStartAddrQ.pop_front();
                    el = expStartLenQ.pop_front();
                    checkOutput("dma_num_trans", 64'(dma_num_trans), 64'(el));
                    checkOutput("dma_start_addr", 64'(dma_start_addr), 64'(ea));
                end
            end
            if (rd0_vld) begin
                if (expRd0Q.size() == 0) reportFail("unexpected_rd0_vld");
                else checkOutput("rd0_data", 64'(rd0_data), 64'(expRd0Q.pop_front()));
            end
            if (rd1_vld) begin
                if (expRd1Q.size() == 0) reportFail("unexpected_rd1_vld");
                else checkOutput("rd1_data", 64'(rd1_data), 64'(expRd1Q.pop_front()));
            end
            if (rd0_done) begin
                if (expDone0Q.size() == 0) reportFail("unexpected_rd0_done");
                else begin
                    ed = expDone0Q.pop_front();
                    checkOutput("rd0_done_with_last_beat", 64'(rd0_vld), 64'(ed));
                end
            end
            if (rd1_done) begin
                if (expDone1Q.size() == 0) reportFail("unexpected_rd1_done");
                else begin
                    ed = expDone1Q.pop_front();
                    checkOutput("rd1_done_with_last_beat", 64'(rd1_vld), 64'(ed));
                end
            end
        end
    end

    // Directed scenario sequence.
    initial begin
        int gapCnt;
        bit seen;
        rstn         = 1'b0;
        req0_valid   = 1'b1;
        req1_valid   = 1'b0;
        req0_addr    = 32'h0000_0100;
        req0_len     = 18'd5;
        req1_addr    = '0;
        req1_len     = '0;
        dma_data     = '0;
        dma_data_vld = 1'b0;
        dma_done     = 1'b0;
        #2;
        checkOutput("reset_req0_ready", 64'(req0_ready), 64'(0));
        checkOutput("reset_busy", 64'(busy), 64'(0));
        checkOutput("reset_dma_start", 64'(dma_start), 64'(0));
        checkOutput("reset_cnt_err", 64'(cnt_err), 64'(0));
        tick();
        req0_valid = 1'b0;
        tick();
        rstn = 1'b1;
        tick();

        $display("[TB] contention: req0 first, req1 after the gap, then req0 again");
        req0_addr = 32'h0000_2000;
        req0_len  = 18'd16;
        req1_addr = 32'h0000_3000;
        req1_len  = 18'd16;
        applyStimulus(1'b1, 1'b1, 0, 16, 1'b1, 1'b1);
        engineRun(32'h0000_2000, 16, 1'b1);
        // Counted from the cycle dma_done is driven until req1_ready shows.
        gapCnt = 1;
        while (!req1_ready && gapCnt < 50) begin
            tick();
            gapCnt++;
        end
        checkOutput("done_to_next_accept", 64'(gapCnt), 64'(1 + GAP));
        applyStimulus(1'b0, 1'b1, 1, 16, 1'b1, 1'b1);
        engineRun(32'h0000_3000, 16, 1'b1);
        waitIdle();
        req0_addr = 32'h0000_2400;
        req0_len  = 18'd2;
        applyStimulus(1'b1, 1'b1, 0, 2, 1'b1, 1'b1);
        req1_valid = 1'b0;
        engineRun(32'h0000_2400, 2, 1'b1);

        $display("[TB] long job on req0");
        waitIdle();
        req0_addr = 32'h0000_1000;
        req0_len  = 18'd300;
        applyStimulus(1'b1, 1'b0, 0, 300, 1'b1, 1'b1);
        engineRun(32'h0000_1000, 300, 1'b1);
        tick();
        checkOutput("cnt_err_after_clean_job", 64'(cnt_err), 64'(0));

        $display("[TB] zero-length job on req1");
        waitIdle();
        req1_addr = 32'h0000_5000;
        req1_len  = 18'd0;
        applyStimulus(1'b0, 1'b1, 1, 0, 1'b0, 1'b1);
        checkOutput("zero_rd1_done", 64'(rd1_done), 64'(1));
        checkOutput("zero_busy", 64'(busy), 64'(1));
        tick();
        checkOutput("zero_rd1_done_drop", 64'(rd1_done), 64'(0));
        checkOutput("zero_busy_drop", 64'(busy), 64'(0));

        $display("[TB] stray engine activity in IDLE and GAP");
        strayPulses(2);
        tick();
        checkOutput("stray_idle_rd_vld", 64'({rd0_vld, rd1_vld}), 64'(0));
        checkOutput("stray_idle_rd_done", 64'({rd0_done, rd1_done}), 64'(0));
        checkOutput("stray_idle_busy", 64'(busy), 64'(0));
        req0_addr = 32'h0000_6000;
        req0_len  = 18'd3;
        applyStimulus(1'b1, 1'b0, 0, 3, 1'b1, 1'b1);
        engineRun(32'h0000_6000, 3, 1'b1);
        strayPulses(2);
        waitIdle();
        checkOutput("stray_gap_cnt_err", 64'(cnt_err), 64'(0));

        $display("[TB] short beat count sets sticky cnt_err");
        req0_addr = 32'h0000_7000;
        req0_len  = 18'd8;
        applyStimulus(1'b1, 1'b0, 0, 7, 1'b0, 1'b1);
        engineRun(32'h0000_7000, 7, 1'b0);
        checkOutput("cnt_err_set", 64'(cnt_err), 64'(1));
        waitIdle();
        req1_addr = 32'h0000_8000;
        req1_len  = 18'd4;
        applyStimulus(1'b0, 1'b1, 1, 4, 1'b1, 1'b1);
        engineRun(32'h0000_8000, 4, 1'b1);
        tick();
        checkOutput("cnt_err_sticky", 64'(cnt_err), 64'(1));

        $display("[TB] reset in the middle of a job");
        waitIdle();
        req0_addr = 32'h0000_9000;
        req0_len  = 18'd64;
        applyStimulus(1'b1, 1'b0, 0, 5, 1'b0, 1'b0);
        waitStart(seen);
        tick();
        for (int i = 0; i < 5; i++) begin
            dma_data_vld = 1'b1;
            dma_data     = dataPat(32'h0000_9000, i);
            tick();
        end
        dma_data_vld = 1'b0;
        tick();
        tick();
        req1_addr  = 32'h0000_A000;
        req1_len   = 18'd4;
        req1_valid = 1'b1;
        rstn       = 1'b0;
        #1;
        checkOutput("rst_ready", 64'({req0_ready, req1_ready}), 64'(0));
        checkOutput("rst_dma_start", 64'(dma_start), 64'(0));
        checkOutput("rst_dma_num_trans", 64'(dma_num_trans), 64'(0));
        checkOutput("rst_dma_start_addr", 64'(dma_start_addr), 64'(0));
        checkOutput("rst_rd0", 64'({rd0_data, rd0_vld, rd0_done}), 64'(0));
        checkOutput("rst_rd1", 64'({rd1_data, rd1_vld, rd1_done}), 64'(0));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_cnt_err", 64'(cnt_err), 64'(0));
        tick();
        tick();
        rstn = 1'b1;
        applyStimulus(1'b0, 1'b1, 1, 4, 1'b1, 1'b1);
        engineRun(32'h0000_A000, 4, 1'b1);
        waitIdle();
        checkOutput("post_reset_cnt_err", 64'(cnt_err), 64'(0));

        tick();
        tick();
        checkOutput("left_start", 64'(expStartLenQ.size()), 64'(0));
        checkOutput("left_rd0", 64'(expRd0Q.size()), 64'(0));
        checkOutput("left_rd1", 64'(expRd1Q.size()), 64'(0));
        checkOutput("left_done0", 64'(expDone0Q.size()), 64'(0));
        checkOutput("left_done1", 64'(expDone1Q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
